i2c_xfer_ctrl: RTL and testbench

I2C_XFER_CTRL -- requirements
Module: i2c_xfer_ctrl

---
 rtl/i2c_xfer_ctrl_pkg.sv | 18 +
 rtl/i2c_xfer_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_i2c_xfer_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_xfer_ctrl_pkg.sv
// Shared bit-transmitter command codes used between the transfer controller
// and the bit transmitter.
package i2c_xfer_ctrl_pkg;

    localparam logic [2:0] CMDIDLE  = 3'd0;
    localparam logic [2:0] CMDSTART = 3'd1;
    localparam logic [2:0] CMDSTOP  = 3'd2;
    localparam logic [2:0] CMDBIT0  = 3'd3;
    localparam logic [2:0] CMDBIT1  = 3'd4;
    localparam logic [2:0] CMDRBIT  = 3'd5;
    localparam logic [2:0] CMDWAIT  = 3'd6;

    // Map a data bit onto the matching bit-write command.
    function automatic logic [2:0] bit_cmd(input logic b);
        return b ? CMDBIT1 : CMDBIT0;
    endfunction

endpackage

// File: rtl/i2c_xfer_ctrl.sv
// Single-byte I2C transfer controller: sequences START, address, ack, one data
// byte (write or read) and STOP through the bit transmitter, one command per
// bit with an ISSUE/RELEASE handshake on bx_ready.
module i2c_xfer_ctrl
    import i2c_xfer_ctrl_pkg::*;
#(
    parameter logic ABORT_ON_NACK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nack,
    output logic [2:0] bx_cmd,
    input  logic       bx_ready,
    input  logic       bx_sck,
    input  logic       bx_sda
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA,
        S_WACK, S_RDATA, S_MNACK, S_STOP, S_DONE
    } state_t;

    typedef enum logic {PH_ISSUE, PH_RELEASE} phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [3:0]  bitcnt, bitcnt_n;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        sck_q;
    logic        cap;
    logic        got;
    logic        advance;
    logic [2:0]  step_cmd;
    logic [2:0]  sel;
    logic [7:0]  addr_frame;
    logic        is_rbit;
    logic        sck_rise;
    logic        bit_now;

    assign addr_frame = {addr_q, rw_q};
    assign sel        = 3'd7 - bitcnt[2:0];
    assign is_rbit    = (state == S_AACK) || (state == S_WACK) || (state == S_RDATA);
    assign sck_rise   = bx_sck & ~sck_q;
    // A rise seen in the step's final cycle still counts for that step.
    assign bit_now    = (is_rbit && sck_rise && !got) ? bx_sda : cap;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);

    // State, phase and bit-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            phase  <= PH_ISSUE;
            bitcnt <= '0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            bitcnt <= bitcnt_n;
        end
    end

    // Next-state, handshake phase and command selection.
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        bitcnt_n = bitcnt;
        advance  = 1'b0;
        bx_cmd   = CMDIDLE;

        case (state)
            S_START:              step_cmd = CMDSTART;
            S_ADDR:               step_cmd = bit_cmd(addr_frame[sel]);
            S_WDATA:              step_cmd = bit_cmd(wdata_q[sel]);
            S_AACK, S_WACK,
            S_RDATA:              step_cmd = CMDRBIT;
            S_MNACK:              step_cmd = CMDBIT1;
            S_STOP:               step_cmd = CMDSTOP;
            default:              step_cmd = CMDIDLE;
        endcase

        case (state)
            S_IDLE: begin
                if (req) begin
                    state_n  = S_START;
                    phase_n  = PH_ISSUE;
                    bitcnt_n = '0;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                phase_n = PH_ISSUE;
            end
            default: begin
                if (phase == PH_ISSUE) begin
                    bx_cmd = step_cmd;
                    if (bx_ready) phase_n = PH_RELEASE;
                end else begin
                    bx_cmd = CMDWAIT;
                    if (!bx_ready) begin
                        advance = 1'b1;
                        phase_n = PH_ISSUE;
                        case (state)
                            S_START: begin
                                state_n  = S_ADDR;
                                bitcnt_n = '0;
                            end
                            S_ADDR: begin
                                if (bitcnt == 4'd7) begin
                                    state_n  = S_AACK;
                                    bitcnt_n = '0;
                                end else begin
                                    bitcnt_n = bitcnt + 4'd1;
                                end
                            end
                            S_AACK: begin
                                bitcnt_n = '0;
                                if (bit_now && ABORT_ON_NACK) state_n = S_STOP;
                                else if (rw_q)                state_n = S_RDATA;
                                else                          state_n = S_WDATA;
                            end
                            S_WDATA: begin
                                if (bitcnt == 4'd7) begin
                                    state_n  = S_WACK;
                                    bitcnt_n = '0;
                                end else begin
                                    bitcnt_n = bitcnt + 4'd1;
                                end
                            end
                            S_WACK:  state_n = S_STOP;
                            S_RDATA: begin
                                if (bitcnt == 4'd7) begin
                                    state_n  = S_MNACK;
                                    bitcnt_n = '0;
                                end else begin
                                    bitcnt_n = bitcnt + 4'd1;
                                end
                            end
                            S_MNACK: state_n = S_STOP;
                            S_STOP:  state_n = S_DONE;
                            default: state_n = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Request latching, SCK edge capture and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            nack    <= 1'b0;
            sck_q   <= 1'b0;
            cap     <= 1'b1;
            got     <= 1'b0;
        end else begin
            sck_q <= bx_sck;
            if (state == S_IDLE && req) begin
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
                rdata   <= '0;
                nack    <= 1'b0;
            end
            if (advance) begin
                got <= 1'b0;
                cap <= 1'b1;
                if (state == S_AACK || state == S_WACK) nack <= bit_now;
                if (state == S_RDATA) rdata <= {rdata[6:0], bit_now};
            end else if (!is_rbit) begin
                got <= 1'b0;
                cap <= 1'b1;
            end else if (sck_rise && !got) begin
                got <= 1'b1;
                cap <= bx_sda;
            end
        end
    end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Self-checking bench for i2c_xfer_ctrl: a cycle-level bit-transmitter/slave
// responder with random handshake delays, checked against a transaction-level
// model of the expected command stream and results.
module tb_i2c_xfer_ctrl;
    import i2c_xfer_ctrl_pkg::*;

    localparam logic ABORT = 1'b1;

    logic       clk = 1'b0;
    logic       reset, req, rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, nack;
    logic [7:0] rdata;
    logic [2:0] bx_cmd;
    logic       bx_ready, bx_sck, bx_sda;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2c_xfer_ctrl #(.ABORT_ON_NACK(ABORT)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .nack(nack), .bx_cmd(bx_cmd),
        .bx_ready(bx_ready), .bx_sck(bx_sck), .bx_sda(bx_sda)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Slave responses for a read: index 0 = address ack, 1..8 = data MSB first.
    function automatic logic [9:0] rd_slv(input logic a_nack, input logic [7:0] b);
        logic [9:0] s;
        s = '0;
        s[0] = a_nack;
        for (int k = 1; k <= 8; k++) s[k] = b[8-k];
        return s;
    endfunction

    task automatic run_xfer(input logic [6:0] a, input logic r, input logic [7:0] wd,
                            input logic [9:0] slv, input logic [9:0] norise,
                            input int unsigned poke, input int unsigned rst_at);
        logic [2:0]  expq[$];
        logic [2:0]  gotq[$];
        logic [9:0]  eff;
        logic        exp_nack;
        logic [7:0]  exp_rdata;
        logic [2:0]  cur;
        logic [7:0]  rd_o;
        logic        nk_o;
        int unsigned rs, dly, rbi, ndone, cyc;
        bit          finished, rst_hit;

        // Reference: the transfer expressed directly as its sequence of bus operations.
        eff = slv | norise;
        exp_nack  = eff[0];
        exp_rdata = '0;
        expq.push_back(CMDSTART);
        for (int i = 6; i >= 0; i--) expq.push_back(a[i] ? CMDBIT1 : CMDBIT0);
        expq.push_back(r ? CMDBIT1 : CMDBIT0);
        expq.push_back(CMDRBIT);
        if (!(eff[0] && ABORT)) begin
            if (!r) begin
                for (int i = 7; i >= 0; i--) expq.push_back(wd[i] ? CMDBIT1 : CMDBIT0);
                expq.push_back(CMDRBIT);
                exp_nack = eff[1];
            end else begin
                for (int k = 1; k <= 8; k++) begin
                    expq.push_back(CMDRBIT);
                    exp_rdata = {exp_rdata[6:0], eff[k]};
                end
                expq.push_back(CMDBIT1);
            end
        end
        expq.push_back(CMDSTOP);

        @(negedge clk);
        addr = a; rw = r; wdata = wd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_req", busy, 1);
        chk("nack_cleared", nack, 0);
        chk("rdata_cleared", rdata, 0);

        rs = 0; dly = 0; rbi = 0; ndone = 0; cyc = 0; cur = CMDIDLE;
        finished = 0; rst_hit = 0; rd_o = '0; nk_o = 1'b0;
        while (!finished && cyc < 3000) begin
            if (done) begin
                ndone++;
                chk("busy_at_done", busy, 0);
                rd_o = rdata;
                nk_o = nack;
                req  = 1'b0;
                finished = 1;
            end else begin
                if (poke != 0) begin
                    req = 1'($urandom_range(0, 1));
                    addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
                end
                case (rs)
                    0: if (bx_cmd != CMDIDLE && bx_cmd != CMDWAIT) begin
                        gotq.push_back(bx_cmd);
                        cur = bx_cmd;
                        dly = $urandom_range(0, 3);
                        rs  = 1;
                        if (rst_at != 0 && gotq.size() == rst_at) rst_hit = 1;
                    end
                    1: begin
                        chk("cmd_hold", bx_cmd, cur);
                        if (dly > 0) dly--;
                        else begin
                            if (cur == CMDRBIT && rbi < 10) begin
                                if (!norise[rbi]) bx_sck = 1'b1;
                                bx_sda = slv[rbi];
                                rbi++;
                            end
                            bx_ready = 1'b1;
                            rs = 2;
                        end
                    end
                    2: begin
                        chk("cmd_wait", bx_cmd, CMDWAIT);
                        dly = $urandom_range(0, 3);
                        rs  = 3;
                    end
                    default: begin
                        chk("wait_hold", bx_cmd, CMDWAIT);
                        if (dly > 0) dly--;
                        else begin
                            bx_ready = 1'b0;
                            bx_sck   = 1'b0;
                            rs = 0;
                        end
                    end
                endcase
                if (rst_hit) begin
                    reset = 1'b1; req = 1'b0; bx_ready = 1'b0; bx_sck = 1'b0;
                    @(negedge clk);
                    chk("rst_cmd_idle", bx_cmd, CMDIDLE);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    reset = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk);
                        chk("rst_no_done", done, 0);
                        chk("rst_stay_idle", bx_cmd, CMDIDLE);
                    end
                    finished = 1;
                end
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        req = 1'b0;

        if (rst_at == 0) begin
            chk("done_count", ndone, 1);
            chk("seq_len", gotq.size(), expq.size());
            for (int i = 0; i < gotq.size() && i < expq.size(); i++)
                chk($sformatf("seq[%0d]", i), gotq[i], expq[i]);
            chk("rdata", rd_o, exp_rdata);
            chk("nack", nk_o, exp_nack);
        end else begin
            chk("rst_done_count", ndone, 0);
            chk("rst_seq_len", gotq.size(), rst_at);
            for (int i = 0; i < gotq.size() && i < expq.size(); i++)
                chk($sformatf("rst_seq[%0d]", i), gotq[i], expq[i]);
        end
    endtask

    initial begin
        logic [9:0] s, nr;
        reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        bx_ready = 1'b0; bx_sck = 1'b0; bx_sda = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_nack", nack, 0);
        chk("reset_cmd", bx_cmd, CMDIDLE);
        reset = 1'b0;
        @(negedge clk);

        // Write 0x50 / 0xA5, both acked; then confirm done stays a single pulse.
        run_xfer(7'h50, 1'b0, 8'hA5, 10'b0, 10'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_done_low", done, 0);
            chk("post_idle_cmd", bx_cmd, CMDIDLE);
        end

        // Read 0x68, slave returns 0x3C.
        run_xfer(7'h68, 1'b1, 8'h00, rd_slv(1'b0, 8'h3C), 10'b0, 0, 0);
        // Address NACK aborts straight to STOP.
        run_xfer(7'h2A, 1'b0, 8'hFF, 10'b01, 10'b0, 0, 0);
        // Read with address NACK also aborts; rdata stays cleared.
        run_xfer(7'h33, 1'b1, 8'h00, rd_slv(1'b1, 8'hFF), 10'b0, 0, 0);
        // Spurious req/inputs toggling throughout the transfer and in DONE.
        run_xfer(7'h11, 1'b0, 8'h3C, 10'b0, 10'b0, 1, 0);
        run_xfer(7'h45, 1'b1, 8'h00, rd_slv(1'b0, 8'h96), 10'b0, 1, 0);
        // No SCK rise on the write ack: captured bit defaults to 1.
        run_xfer(7'h7F, 1'b0, 8'h00, 10'b0, 10'b10, 0, 0);
        // No SCK rise on two read bits: those bits read as 1.
        run_xfer(7'h01, 1'b1, 8'h00, rd_slv(1'b0, 8'h00), 10'b0000100100, 0, 0);
        // Reset during the first data bit of a write.
        run_xfer(7'h50, 1'b0, 8'hA5, 10'b0, 10'b0, 0, 11);

        for (int n = 0; n < 20; n++) begin
            s  = 10'($urandom);
            s[0] = ($urandom_range(0, 4) == 0);
            nr = ($urandom_range(0, 3) == 0) ? 10'(1 << $urandom_range(0, 9)) : 10'b0;
            run_xfer(7'($urandom), 1'($urandom), 8'($urandom), s, nr, $urandom_range(0, 1), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
